vector_floating_point_divide_sequencer: RTL and testbench

Initiator-side controller for the vector floating-point divide datapath. It accepts one divide operation through a valid/ready issue port, drives `execution_vector`/`vs2`/`vs1` into a fixed-latency divide unit, and holds those operands stable for the full latency. It then captures `vd` and presents it on a valid/ready result port. It sits between the vector issue stage and the registered divide unit, and provides the handshake that the bare divide unit does not.

---
 rtl/dragonfang_pkg.sv | 19 +
 rtl/riscv_v_pkg.sv | 10 +
 rtl/vector_floating_point_divide_sequencer.sv | 86 ++++++++
 tb/tb_vector_floating_point_divide_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dragonfang_pkg.sv
// Core-wide types for the dragonfang vector pipeline.
package dragonfang_pkg;

    // Decoded vector operation as handed from issue to the execution units
    typedef struct packed {
        logic [5:0] funct6;
        logic [2:0] vsew;
        logic       vm;
        logic [4:0] vd;
    } execution_vector_t;

    // Divide sequencer control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } divide_sequencer_state_t;

endpackage : dragonfang_pkg

// File: rtl/riscv_v_pkg.sv
// Vector architecture constants shared across the vector unit.
package riscv_v_pkg;

    // Vector register width in bits
    localparam int unsigned VLEN = 128;

    // Widest supported element width in bits
    localparam int unsigned ELEN = 32;

endpackage : riscv_v_pkg

// File: rtl/vector_floating_point_divide_sequencer.sv
// Initiator-side handshake wrapper for the fixed-latency vector FP divide unit.
// Operands are registered on issue and held for the whole divide latency;
// the quotient is captured and offered on a valid/ready result port.
module vector_floating_point_divide_sequencer
    import riscv_v_pkg::*;
    import dragonfang_pkg::*;
#(
    parameter int unsigned DIVIDE_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  execution_vector_t issue_execution_vector,
    input  logic [VLEN-1:0]   issue_vs2,
    input  logic [VLEN-1:0]   issue_vs1,
    output execution_vector_t divide_execution_vector,
    output logic [VLEN-1:0]   divide_vs2,
    output logic [VLEN-1:0]   divide_vs1,
    input  logic [VLEN-1:0]   divide_vd,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [VLEN-1:0]   result_vd,
    output logic              busy
);

    localparam int unsigned COUNT_WIDTH =
        (DIVIDE_LATENCY > 0) ? $clog2(DIVIDE_LATENCY + 1) : 1;

    divide_sequencer_state_t state;
    logic [COUNT_WIDTH-1:0]  latency_count;
    logic                    issue_fire;

    // A new operation may enter when idle, or in the same edge the held result drains
    assign issue_ready = (state == IDLE) || ((state == HOLD) && result_ready);
    assign issue_fire  = issue_valid && issue_ready;
    assign busy        = (state != IDLE);

    // Sequencer FSM: operand registers, latency countdown, result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            latency_count           <= '0;
            divide_execution_vector <= '0;
            divide_vs2              <= '0;
            divide_vs1              <= '0;
            result_valid            <= 1'b0;
            result_vd               <= '0;
        end else begin
            // issue_fire is only possible from IDLE or HOLD, so loading here never disturbs WAIT
            if (issue_fire) begin
                divide_execution_vector <= issue_execution_vector;
                divide_vs2              <= issue_vs2;
                divide_vs1              <= issue_vs1;
                latency_count           <= COUNT_WIDTH'(DIVIDE_LATENCY);
            end

            case (state)
                IDLE: begin
                    if (issue_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (latency_count != '0) begin
                        latency_count <= latency_count - COUNT_WIDTH'(1);
                    end else begin
                        result_vd    <= divide_vd;
                        result_valid <= 1'b1;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= issue_fire ? WAIT : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : vector_floating_point_divide_sequencer

// File: tb/tb_vector_floating_point_divide_sequencer.sv
// Directed bench for the vector FP divide sequencer with a two-stage divide unit model.
module tb_vector_floating_point_divide_sequencer;
    import riscv_v_pkg::*;
    import dragonfang_pkg::*;

    localparam int unsigned LANES = VLEN / 32;

    localparam logic [31:0] FP_ONE     = 32'h3F800000;
    localparam logic [31:0] FP_TWO     = 32'h40000000;
    localparam logic [31:0] FP_THREE   = 32'h40400000;
    localparam logic [31:0] FP_FOUR    = 32'h40800000;
    localparam logic [31:0] FP_SIX     = 32'h40C00000;
    localparam logic [31:0] FP_HALF    = 32'h3F000000;
    localparam logic [31:0] FP_QUARTER = 32'h3E800000;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

    logic              clock;
    logic              reset_n;
    logic              issue_valid;
    logic              issue_ready;
    execution_vector_t issue_execution_vector;
    logic [VLEN-1:0]   issue_vs2;
    logic [VLEN-1:0]   issue_vs1;
    execution_vector_t divide_execution_vector;
    logic [VLEN-1:0]   divide_vs2;
    logic [VLEN-1:0]   divide_vs1;
    logic [VLEN-1:0]   divide_vd;
    logic              result_valid;
    logic              result_ready;
    logic [VLEN-1:0]   result_vd;
    logic              busy;

    logic [VLEN-1:0]   model_stage;

    int unsigned check_count;
    int unsigned fail_count;

    vector_floating_point_divide_sequencer #(
        .DIVIDE_LATENCY(2)
    ) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .issue_valid            (issue_valid),
        .issue_ready            (issue_ready),
        .issue_execution_vector (issue_execution_vector),
        .issue_vs2              (issue_vs2),
        .issue_vs1              (issue_vs1),
        .divide_execution_vector(divide_execution_vector),
        .divide_vs2             (divide_vs2),
        .divide_vs1             (divide_vs1),
        .divide_vd              (divide_vd),
        .result_valid           (result_valid),
        .result_ready           (result_ready),
        .result_vd              (result_vd),
        .busy                   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand-computed quotients for the operand pairs this bench uses
    function automatic logic [31:0] lane_quotient(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {FP_ONE, FP_TWO}:   return FP_HALF;
            {FP_SIX, FP_THREE}: return FP_TWO;
            {FP_ONE, FP_FOUR}:  return FP_QUARTER;
            default:            return FP_QNAN;
        endcase
    endfunction

    function automatic logic [VLEN-1:0] divide_model(input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        logic [VLEN-1:0] q;
        q = '0;
        for (int i = 0; i < LANES; i++) begin
            q[i*32 +: 32] = lane_quotient(a[i*32 +: 32], b[i*32 +: 32]);
        end
        return q;
    endfunction

    function automatic logic [VLEN-1:0] splat(input logic [31:0] w);
        logic [VLEN-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v[i*32 +: 32] = w;
        end
        return v;
    endfunction

    function automatic logic [VLEN-1:0] mix(input logic [31:0] l0, input logic [31:0] l1,
                                            input logic [31:0] l2, input logic [31:0] l3);
        logic [VLEN-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            case (i % 4)
                0:       v[i*32 +: 32] = l0;
                1:       v[i*32 +: 32] = l1;
                2:       v[i*32 +: 32] = l2;
                default: v[i*32 +: 32] = l3;
            endcase
        end
        return v;
    endfunction

    // Divide unit stand-in: registered input stage and registered output stage
    always @(posedge clock) begin
        model_stage <= divide_model(divide_vs2, divide_vs1);
        divide_vd   <= model_stage;
    end

    task automatic check_equal(input string tag, input logic [VLEN-1:0] actual, input logic [VLEN-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        execution_vector_t ev_a;
        execution_vector_t ev_b;
        execution_vector_t ev_c;
        logic [VLEN-1:0]   junk;
        int unsigned       low_cycles;
        logic              seen_valid;

        check_count = 0;
        fail_count  = 0;
        ev_a = '{funct6: 6'h20, vsew: 3'd2, vm: 1'b1, vd: 5'd3};
        ev_b = '{funct6: 6'h21, vsew: 3'd2, vm: 1'b0, vd: 5'd9};
        ev_c = '{funct6: 6'h20, vsew: 3'd2, vm: 1'b1, vd: 5'd17};

        reset_n                = 1'b0;
        issue_valid            = 1'b0;
        issue_execution_vector = '0;
        issue_vs2              = '0;
        issue_vs1              = '0;
        result_ready           = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_equal("reset_result_valid", VLEN'(result_valid), VLEN'(0));
        check_equal("reset_result_vd", result_vd, '0);
        check_equal("reset_divide_vs2", divide_vs2, '0);
        check_equal("reset_divide_vs1", divide_vs1, '0);
        check_equal("reset_divide_ev", VLEN'(divide_execution_vector), VLEN'(0));
        check_equal("reset_busy", VLEN'(busy), VLEN'(0));
        check_equal("reset_issue_ready", VLEN'(issue_ready), VLEN'(1));
        reset_n = 1'b1;
        step();

        // Single divide: 1.0 / 2.0 in every lane
        issue_valid            = 1'b1;
        issue_execution_vector = ev_a;
        issue_vs2              = splat(FP_ONE);
        issue_vs1              = splat(FP_TWO);
        #1;
        check_equal("idle_issue_ready", VLEN'(issue_ready), VLEN'(1));
        step();  // E0
        issue_valid = 1'b0;
        check_equal("e0_busy", VLEN'(busy), VLEN'(1));
        check_equal("e0_divide_vs2", divide_vs2, splat(FP_ONE));
        check_equal("e0_divide_vs1", divide_vs1, splat(FP_TWO));
        check_equal("e0_divide_ev", VLEN'(divide_execution_vector), VLEN'(ev_a));
        check_equal("e0_result_valid", VLEN'(result_valid), VLEN'(0));
        step();  // E1
        check_equal("e1_result_valid", VLEN'(result_valid), VLEN'(0));
        step();  // E2
        check_equal("e2_result_valid", VLEN'(result_valid), VLEN'(0));
        check_equal("e2_busy", VLEN'(busy), VLEN'(1));
        step();  // E3
        check_equal("e3_result_valid", VLEN'(result_valid), VLEN'(1));
        check_equal("e3_result_vd", result_vd, splat(FP_HALF));

        // Backpressure: new operation offered while the result is not consumed
        issue_valid            = 1'b1;
        issue_execution_vector = ev_b;
        issue_vs2              = splat(FP_SIX);
        issue_vs1              = splat(FP_THREE);
        for (int c = 0; c < 5; c++) begin
            #1;
            check_equal("hold_issue_ready", VLEN'(issue_ready), VLEN'(0));
            step();
            check_equal("hold_result_valid", VLEN'(result_valid), VLEN'(1));
            check_equal("hold_result_vd", result_vd, splat(FP_HALF));
            check_equal("hold_divide_vs2", divide_vs2, splat(FP_ONE));
            check_equal("hold_divide_ev", VLEN'(divide_execution_vector), VLEN'(ev_a));
            check_equal("hold_busy", VLEN'(busy), VLEN'(1));
        end

        // Back-to-back: consume and issue in the same edge
        result_ready = 1'b1;
        #1;
        check_equal("b2b_issue_ready", VLEN'(issue_ready), VLEN'(1));
        step();  // E0'
        result_ready = 1'b0;
        check_equal("b2b_divide_ev", VLEN'(divide_execution_vector), VLEN'(ev_b));
        low_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            if (result_valid) break;
            low_cycles++;
            // Scramble issue operands during WAIT; they must be ignored
            for (int i = 0; i < LANES; i++) begin
                junk[i*32 +: 32] = $urandom;
            end
            issue_vs2   = junk;
            issue_vs1   = ~junk;
            issue_valid = 1'b1;
            check_equal("wait_divide_vs2", divide_vs2, splat(FP_SIX));
            check_equal("wait_divide_vs1", divide_vs1, splat(FP_THREE));
            step();
        end
        check_equal("b2b_low_cycles", VLEN'(low_cycles), VLEN'(3));
        check_equal("b2b_result_valid", VLEN'(result_valid), VLEN'(1));
        check_equal("b2b_result_vd", result_vd, splat(FP_TWO));

        // Consume without a new issue
        issue_valid  = 1'b0;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_equal("drain_result_valid", VLEN'(result_valid), VLEN'(0));
        check_equal("drain_busy", VLEN'(busy), VLEN'(0));
        check_equal("drain_issue_ready", VLEN'(issue_ready), VLEN'(1));
        check_equal("drain_result_vd_kept", result_vd, splat(FP_TWO));

        // Reset one cycle into WAIT
        issue_valid            = 1'b1;
        issue_execution_vector = ev_c;
        issue_vs2              = mix(FP_ONE, FP_SIX, FP_ONE, FP_ONE);
        issue_vs1              = mix(FP_TWO, FP_THREE, FP_FOUR, FP_TWO);
        step();  // E0
        issue_valid = 1'b0;
        step();  // E1
        reset_n = 1'b0;
        #1;
        check_equal("rst_busy", VLEN'(busy), VLEN'(0));
        check_equal("rst_issue_ready", VLEN'(issue_ready), VLEN'(1));
        check_equal("rst_result_valid", VLEN'(result_valid), VLEN'(0));
        check_equal("rst_result_vd", result_vd, '0);
        check_equal("rst_divide_vs2", divide_vs2, '0);
        check_equal("rst_divide_vs1", divide_vs1, '0);
        check_equal("rst_divide_ev", VLEN'(divide_execution_vector), VLEN'(0));
        step();
        step();
        reset_n    = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            seen_valid = seen_valid | result_valid;
        end
        check_equal("post_rst_no_valid", VLEN'(seen_valid), VLEN'(0));
        check_equal("post_rst_busy", VLEN'(busy), VLEN'(0));

        // Fresh operation with mixed lanes completes normally
        issue_valid = 1'b1;
        step();  // E0
        issue_valid = 1'b0;
        check_equal("mix_divide_ev", VLEN'(divide_execution_vector), VLEN'(ev_c));
        step();
        step();  // E2
        check_equal("mix_e2_result_valid", VLEN'(result_valid), VLEN'(0));
        step();  // E3
        check_equal("mix_e3_result_valid", VLEN'(result_valid), VLEN'(1));
        check_equal("mix_result_vd", result_vd, mix(FP_HALF, FP_TWO, FP_QUARTER, FP_HALF));
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check_equal("mix_drain_result_valid", VLEN'(result_valid), VLEN'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule : tb_vector_floating_point_divide_sequencer
